// File: rtl/oled_spi_scheduler_if.sv
// Requester streams and serializer handshake for the OLED SPI scheduler.
// Signal names are given from the scheduler's point of view.
interface oled_spi_scheduler_if;
  // Command byte stream (DC=0)
  logic       i_a_valid;
  logic [7:0] i_a_data;
  logic       i_a_last;
  logic       o_a_ready;
  // RGB565 pixel stream (DC=1, high byte first)
  logic        i_b_valid;
  logic [15:0] i_b_data;
  logic        i_b_last;
  logic        o_b_ready;
  // Byte serializer controls
  logic       o_cmd_set;
  logic       o_next_byte;
  logic       o_cmd_reset;
  logic [7:0] o_tx_data;
  logic       i_done;

  // Requesters and serializer side
  modport master (
    output i_a_valid, i_a_data, i_a_last, i_b_valid, i_b_data, i_b_last, i_done,
    input  o_a_ready, o_b_ready, o_cmd_set, o_next_byte, o_cmd_reset, o_tx_data
  );

  // Scheduler side
  modport slave (
    input  i_a_valid, i_a_data, i_a_last, i_b_valid, i_b_data, i_b_last, i_done,
    output o_a_ready, o_b_ready, o_cmd_set, o_next_byte, o_cmd_reset, o_tx_data
  );
endinterface

// File: rtl/oled_spi_scheduler.sv
// Transaction scheduler for the PmodOLEDrgb SPI path: panel reset sequencing,
// round-robin arbitration between command and pixel streams, and byte pacing
// into the serializer against its done pulse. All outputs are registered.
module oled_spi_scheduler #(
  parameter int unsigned RST_LOW_CYC  = 2000,
  parameter int unsigned RST_WAIT_CYC = 2000,
  parameter int unsigned GAP_CYC      = 16
) (
  input  logic                 i_clk,
  input  logic                 i_n_reset,
  oled_spi_scheduler_if.slave  bus,
  output logic                 o_sclk_en,
  output logic                 o_cs_n,
  output logic                 o_dc,
  output logic                 o_res_n,
  output logic                 o_init_done,
  output logic                 o_busy,
  output logic                 o_underrun
);

  localparam int unsigned MaxRst = (RST_LOW_CYC > RST_WAIT_CYC) ? RST_LOW_CYC : RST_WAIT_CYC;
  localparam int unsigned MaxCyc = (MaxRst > GAP_CYC) ? MaxRst : GAP_CYC;
  localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;
  localparam int unsigned GapEff = (GAP_CYC > 0) ? GAP_CYC : 1;

  localparam logic [CntW-1:0] LowLast  = CntW'(RST_LOW_CYC - 1);
  localparam logic [CntW-1:0] WaitLast = CntW'(RST_WAIT_CYC - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(GapEff - 1);

  typedef enum logic [2:0] {
    StResLow,
    StResWait,
    StIdle,
    StStart,
    StShift,
    StFinish,
    StGap
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            sel_b_q;    // current grant is the pixel stream
  logic            last_b_q;   // last grant went to the pixel stream
  logic            lo_pend_q;  // pixel low byte still to be sent
  logic            last_q;     // most recent byte/beat carried last
  logic [15:0]     hold_q;

  logic grant_b;
  logic gnt_valid;
  logic load_now;

  // Tie goes to whichever requester was not granted last
  assign grant_b   = bus.i_b_valid && (!bus.i_a_valid || !last_b_q);
  assign gnt_valid = sel_b_q ? bus.i_b_valid : bus.i_a_valid;
  // Consume a new byte/beat from the granted requester this cycle
  assign load_now  = (state_q == StStart) ||
                     ((state_q == StShift) && bus.i_done && !lo_pend_q && !last_q && gnt_valid);

  // Single FSM with registered panel, serializer and handshake outputs
  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      state_q         <= StResLow;
      cnt_q           <= '0;
      sel_b_q         <= 1'b0;
      last_b_q        <= 1'b0;
      lo_pend_q       <= 1'b0;
      last_q          <= 1'b0;
      hold_q          <= '0;
      bus.o_a_ready   <= 1'b0;
      bus.o_b_ready   <= 1'b0;
      bus.o_cmd_set   <= 1'b0;
      bus.o_next_byte <= 1'b0;
      bus.o_cmd_reset <= 1'b0;
      bus.o_tx_data   <= 8'h00;
      o_sclk_en       <= 1'b0;
      o_cs_n          <= 1'b1;
      o_dc            <= 1'b0;
      o_res_n         <= 1'b0;
      o_init_done     <= 1'b0;
      o_busy          <= 1'b1;
      o_underrun      <= 1'b0;
    end else begin
      bus.o_a_ready   <= 1'b0;
      bus.o_b_ready   <= 1'b0;
      bus.o_cmd_set   <= 1'b0;
      bus.o_next_byte <= 1'b0;
      bus.o_cmd_reset <= 1'b0;

      if (load_now) begin
        if (sel_b_q) begin
          hold_q        <= bus.i_b_data;
          bus.o_tx_data <= bus.i_b_data[15:8];
          lo_pend_q     <= 1'b1;
          last_q        <= bus.i_b_last;
          bus.o_b_ready <= 1'b1;
        end else begin
          bus.o_tx_data <= bus.i_a_data;
          last_q        <= bus.i_a_last;
          bus.o_a_ready <= 1'b1;
        end
      end

      unique case (state_q)
        StResLow: begin
          if (cnt_q == LowLast) begin
            o_res_n <= 1'b1;
            cnt_q   <= '0;
            state_q <= StResWait;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StResWait: begin
          if (cnt_q == WaitLast) begin
            o_init_done <= 1'b1;
            o_busy      <= 1'b0;
            cnt_q       <= '0;
            state_q     <= StIdle;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StIdle: begin
          if (bus.i_a_valid || bus.i_b_valid) begin
            sel_b_q  <= grant_b;
            last_b_q <= grant_b;
            o_busy   <= 1'b1;
            state_q  <= StStart;
          end
        end
        StStart: begin
          o_cs_n        <= 1'b0;
          o_dc          <= sel_b_q;
          o_sclk_en     <= 1'b1;
          bus.o_cmd_set <= 1'b1;
          state_q       <= StShift;
        end
        StShift: begin
          if (bus.i_done) begin
            if (lo_pend_q) begin
              bus.o_next_byte <= 1'b1;
              bus.o_tx_data   <= hold_q[7:0];
              lo_pend_q       <= 1'b0;
            end else if (last_q) begin
              state_q <= StFinish;
            end else if (gnt_valid) begin
              bus.o_next_byte <= 1'b1;
            end else begin
              o_underrun <= 1'b1;
              state_q    <= StFinish;
            end
          end
        end
        StFinish: begin
          bus.o_cmd_reset <= 1'b1;
          o_cs_n          <= 1'b1;
          o_sclk_en       <= 1'b0;
          cnt_q           <= '0;
          state_q         <= StGap;
        end
        StGap: begin
          if (cnt_q == GapLast) begin
            o_busy  <= 1'b0;
            cnt_q   <= '0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= StResLow;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oled_spi_scheduler.sv
// Self-checking bench for oled_spi_scheduler: queue-driven requesters, a
// serializer model answering each load pulse, and a transaction-level model.
module tb_oled_spi_scheduler;

  localparam int unsigned RL       = 10;
  localparam int unsigned RW       = 5;
  localparam int unsigned GAP      = 4;
  localparam int unsigned DONE_LAT = 20;

  logic clk;
  logic rst_n;
  logic sclk_en, cs_n, dc, res_n, init_done, busy, underrun;

  oled_spi_scheduler_if bus ();

  oled_spi_scheduler #(
    .RST_LOW_CYC  (RL),
    .RST_WAIT_CYC (RW),
    .GAP_CYC      (GAP)
  ) dut (
    .i_clk       (clk),
    .i_n_reset   (rst_n),
    .bus         (bus),
    .o_sclk_en   (sclk_en),
    .o_cs_n      (cs_n),
    .o_dc        (dc),
    .o_res_n     (res_n),
    .o_init_done (init_done),
    .o_busy      (busy),
    .o_underrun  (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requester queues ({last, data}) and model copies
  logic [8:0]  a_q[$];
  logic [16:0] b_q[$];
  logic [8:0]  ma[$];
  logic [16:0] mb[$];
  logic        m_last_b;
  logic        m_underrun;

  // Observations: {was_cmd_set, dc, byte}
  logic [9:0] byte_log[$];
  logic       gnt_log[$];
  int n_set, n_next, n_rst, n_ar, n_br, cs_viol;
  int hi_run, min_gap, gap_cnt, gap_len;
  logic gap_act;

  int n_vec, n_err;

  // Requester A: present queue head, pop on ready
  always @(negedge clk) begin
    if (bus.o_a_ready && a_q.size() > 0) void'(a_q.pop_front());
    if (a_q.size() > 0) begin
      bus.i_a_valid = 1'b1;
      bus.i_a_data  = a_q[0][7:0];
      bus.i_a_last  = a_q[0][8];
    end else begin
      bus.i_a_valid = 1'b0;
      bus.i_a_data  = 8'h00;
      bus.i_a_last  = 1'b0;
    end
  end

  // Requester B
  always @(negedge clk) begin
    if (bus.o_b_ready && b_q.size() > 0) void'(b_q.pop_front());
    if (b_q.size() > 0) begin
      bus.i_b_valid = 1'b1;
      bus.i_b_data  = b_q[0][15:0];
      bus.i_b_last  = b_q[0][16];
    end else begin
      bus.i_b_valid = 1'b0;
      bus.i_b_data  = 16'h0000;
      bus.i_b_last  = 1'b0;
    end
  end

  // Serializer: samples data one cycle after a load pulse, done DONE_LAT later
  int   ser_cd;
  logic cap_pend, cap_set;
  always @(negedge clk) begin
    if (!rst_n) begin
      ser_cd     = 0;
      cap_pend   = 1'b0;
      bus.i_done = 1'b0;
    end else begin
      bus.i_done = 1'b0;
      if (cap_pend) begin
        byte_log.push_back({cap_set, dc, bus.o_tx_data});
        if (cs_n || !sclk_en) cs_viol++;
        cap_pend = 1'b0;
      end
      if (bus.o_cmd_set || bus.o_next_byte) begin
        cap_pend = 1'b1;
        cap_set  = bus.o_cmd_set;
        ser_cd   = DONE_LAT;
      end else if (ser_cd > 0) begin
        ser_cd--;
        if (ser_cd == 0) bus.i_done = 1'b1;
      end
    end
  end

  // Pulse counters, grant order, CS-high run lengths, FINISH-to-IDLE distance
  always @(negedge clk) begin
    if (bus.o_cmd_set) begin
      n_set++;
      gnt_log.push_back(bus.o_b_ready);
    end
    if (bus.o_next_byte) n_next++;
    if (bus.o_cmd_reset) n_rst++;
    if (bus.o_a_ready) n_ar++;
    if (bus.o_b_ready) n_br++;
    if (cs_n) hi_run++;
    else begin
      if (hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
      hi_run = 0;
    end
    if (bus.o_cmd_reset) begin
      gap_cnt = 0;
      gap_act = 1'b1;
    end else if (gap_act) begin
      gap_cnt++;
      if (!busy) begin
        gap_len = gap_cnt;
        gap_act = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_a(input logic [7:0] d, input logic l);
    a_q.push_back({l, d});
    ma.push_back({l, d});
  endtask

  task automatic push_b(input logic [15:0] d, input logic l);
    b_q.push_back({l, d});
    mb.push_back({l, d});
  endtask

  // Counts posedges after reset release until res_n and init_done rise
  task automatic check_init(input string tag);
    int res_k, done_k, cs_bad;
    res_k  = -1;
    done_k = -1;
    cs_bad = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (res_k < 0 && res_n) res_k = k;
      if (done_k < 0 && init_done) done_k = k;
      if (done_k < 0 && !cs_n) cs_bad++;
    end
    check({tag, " res_n_rise"}, res_k, RL);
    check({tag, " init_done_rise"}, done_k, RL + RW);
    check({tag, " cs_before_init"}, cs_bad, 0);
    check({tag, " idle_not_busy"}, int'(busy), 0);
  endtask

  // Drains model queues into expected transactions and compares against the DUT
  task automatic run_phase(input string name);
    logic [9:0]  eb[$];
    logic        eg[$];
    logic [8:0]  ia;
    logic [16:0] ib;
    logic        pick_b, fin, first;
    int et, ea, ebt, budget, waited;
    int b_set, b_next, b_rst, b_ar, b_br;
    et  = 0;
    ea  = 0;
    ebt = 0;
    while (ma.size() > 0 || mb.size() > 0) begin
      pick_b   = (ma.size() > 0 && mb.size() > 0) ? !m_last_b : (mb.size() > 0);
      m_last_b = pick_b;
      eg.push_back(pick_b);
      et++;
      fin   = 1'b0;
      first = 1'b1;
      while (!fin) begin
        if (pick_b) begin
          if (mb.size() == 0) begin
            m_underrun = 1'b1;
            fin        = 1'b1;
          end else begin
            ib = mb.pop_front();
            ebt++;
            eb.push_back({first, 1'b1, ib[15:8]});
            eb.push_back({1'b0, 1'b1, ib[7:0]});
            fin = ib[16];
          end
        end else begin
          if (ma.size() == 0) begin
            m_underrun = 1'b1;
            fin        = 1'b1;
          end else begin
            ia = ma.pop_front();
            ea++;
            eb.push_back({first, 1'b0, ia[7:0]});
            fin = ia[8];
          end
        end
        first = 1'b0;
      end
    end

    byte_log.delete();
    gnt_log.delete();
    b_set  = n_set;
    b_next = n_next;
    b_rst  = n_rst;
    b_ar   = n_ar;
    b_br   = n_br;

    budget = 30 * eb.size() + 20 * et + 100;
    waited = 0;
    while ((n_rst - b_rst) < et && waited < budget) begin
      tick();
      waited++;
    end
    check({name, " txn_complete_in_time"}, int'((n_rst - b_rst) >= et), 1);
    waited = 0;
    while (busy && waited < GAP + 20) begin
      tick();
      waited++;
    end
    check({name, " back_to_idle"}, int'(busy), 0);

    check({name, " byte_count"}, byte_log.size(), eb.size());
    for (int i = 0; i < eb.size() && i < byte_log.size(); i++)
      check($sformatf("%s byte%0d", name, i), int'(byte_log[i]), int'(eb[i]));
    check({name, " grant_count"}, gnt_log.size(), eg.size());
    for (int i = 0; i < eg.size() && i < gnt_log.size(); i++)
      check($sformatf("%s grant%0d_is_b", name, i), int'(gnt_log[i]), int'(eg[i]));
    check({name, " cmd_set"}, n_set - b_set, et);
    check({name, " next_byte"}, n_next - b_next, eb.size() - et);
    check({name, " cmd_reset"}, n_rst - b_rst, et);
    check({name, " a_ready"}, n_ar - b_ar, ea);
    check({name, " b_ready"}, n_br - b_br, ebt);
    check({name, " underrun"}, int'(underrun), int'(m_underrun));
    check({name, " cs_n_idle"}, int'(cs_n), 1);
    check({name, " sclk_en_idle"}, int'(sclk_en), 0);
  endtask

  initial begin
    int base, waited, br_at_reset, kind, na, nb;
    n_vec      = 0;
    n_err      = 0;
    n_set      = 0;
    n_next     = 0;
    n_rst      = 0;
    n_ar       = 0;
    n_br       = 0;
    cs_viol    = 0;
    hi_run     = 0;
    min_gap    = 1 << 30;
    gap_cnt    = 0;
    gap_len    = -1;
    gap_act    = 1'b0;
    m_last_b   = 1'b0;
    m_underrun = 1'b0;

    // Reset values
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst cs_n", int'(cs_n), 1);
    check("rst dc", int'(dc), 0);
    check("rst res_n", int'(res_n), 0);
    check("rst tx_data", int'(bus.o_tx_data), 0);
    check("rst busy", int'(busy), 1);
    check("rst sclk_en", int'(sclk_en), 0);
    check("rst init_done", int'(init_done), 0);
    check("rst underrun", int'(underrun), 0);
    check("rst pulses", int'({bus.o_cmd_set, bus.o_next_byte, bus.o_cmd_reset,
                              bus.o_a_ready, bus.o_b_ready}), 0);
    rst_n = 1'b1;
    check_init("init");

    // Single command
    push_a(8'hAF, 1'b1);
    run_phase("single_cmd");
    check("single_cmd gap_cycles", gap_len, GAP);

    // Pixel burst
    push_b(16'hF800, 1'b0);
    push_b(16'h07E0, 1'b1);
    run_phase("pixel_burst");

    // Arbitration: both streams valid continuously, single-item transactions
    for (int i = 0; i < 3; i++) begin
      push_a(8'($urandom), 1'b1);
      push_b(16'($urandom), 1'b1);
    end
    run_phase("arbitration");
    check("arbitration min_cs_gap_ok", int'(min_gap >= GAP), 1);

    // Underrun: a non-last byte followed by nothing
    push_a(8'h15, 1'b0);
    run_phase("underrun");

    // Reset during the low byte of a pixel beat
    b_q.push_back({1'b1, 16'hA55A});
    base   = n_next;
    waited = 0;
    while (n_next == base && waited < 200) begin
      tick();
      waited++;
    end
    check("midreset reached_low_byte", int'(n_next > base), 1);
    repeat (3) tick();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset cs_n", int'(cs_n), 1);
    check("midreset res_n", int'(res_n), 0);
    check("midreset sclk_en", int'(sclk_en), 0);
    check("midreset busy", int'(busy), 1);
    check("midreset underrun_cleared", int'(underrun), 0);
    check("midreset init_done_cleared", int'(init_done), 0);
    br_at_reset = n_br;
    m_last_b    = 1'b0;
    m_underrun  = 1'b0;
    repeat (3) tick();
    check("midreset no_ready_in_reset", n_br, br_at_reset);
    rst_n = 1'b1;
    check_init("reinit");

    // Randomised traffic
    for (int p = 0; p < 8; p++) begin
      kind = $urandom_range(0, 2);
      na   = $urandom_range(1, 4);
      nb   = $urandom_range(1, 3);
      if (kind != 1)
        for (int i = 0; i < na; i++) push_a(8'($urandom), (i == na - 1));
      if (kind != 0)
        for (int i = 0; i < nb; i++) push_b(16'($urandom), (i == nb - 1));
      run_phase($sformatf("random%0d", p));
    end

    check("bytes_outside_cs", cs_viol, 0);
    check("min_cs_gap_ok", int'(min_gap >= GAP), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
